// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 Set 2 scan code decoder with modifier tracking and event FIFO
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [2:0] evt_mods,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] mods,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((PREFIX_TIMEOUT > 0) ? PREFIX_TIMEOUT - 1 : 0);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t        state, state_n;
  logic [2:0]    skip, skip_n;
  logic [TW-1:0] to_cnt;
  // {ralt, lalt, rctrl, lctrl, rshift, lshift}
  logic [5:0]    mod_q, mod_n;
  logic          key_evt, key_ext, key_brk, pause_evt, fake, push;
  logic [12:0]   push_data;

  always_comb begin
    state_n   = state;
    skip_n    = skip;
    key_evt   = 1'b0;
    key_ext   = 1'b0;
    key_brk   = 1'b0;
    pause_evt = 1'b0;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          case (byte_in)
            8'hE0: state_n = EXT;
            8'hF0: state_n = BRK;
            8'hE1: begin state_n = PAUSE; skip_n = 3'd7; end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: ;
            default: key_evt = 1'b1;
          endcase
        end
        EXT: begin
          case (byte_in)
            8'hF0: state_n = EXT_BRK;
            8'hE0: state_n = EXT;
            8'hE1: begin state_n = PAUSE; skip_n = 3'd7; end
            default: begin key_evt = 1'b1; key_ext = 1'b1; state_n = IDLE; end
          endcase
        end
        BRK: begin
          key_evt = 1'b1; key_brk = 1'b1; state_n = IDLE;
        end
        EXT_BRK: begin
          key_evt = 1'b1; key_ext = 1'b1; key_brk = 1'b1; state_n = IDLE;
        end
        PAUSE: begin
          if (skip == 3'd1) begin
            pause_evt = 1'b1;
            state_n   = IDLE;
          end
          skip_n = skip - 3'd1;
        end
        default: state_n = IDLE;
      endcase
    end

    // E0 12 / E0 59 are keyboard-generated fake shifts around extended keys
    fake  = key_ext && (byte_in == 8'h12 || byte_in == 8'h59);
    mod_n = mod_q;
    if (key_evt && !fake) begin
      case ({key_ext, byte_in})
        9'h012: mod_n[0] = !key_brk;
        9'h059: mod_n[1] = !key_brk;
        9'h014: mod_n[2] = !key_brk;
        9'h114: mod_n[3] = !key_brk;
        9'h011: mod_n[4] = !key_brk;
        9'h111: mod_n[5] = !key_brk;
        default: ;
      endcase
    end
    push      = (key_evt && !fake) || pause_evt;
    push_data = {pause_evt ? 8'hE1 : byte_in, key_ext, key_brk,
                 mod_n[5] | mod_n[4], mod_n[3] | mod_n[2], mod_n[1] | mod_n[0]};
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state  <= IDLE;
      skip   <= '0;
      mod_q  <= '0;
      to_cnt <= '0;
    end else if (byte_valid) begin
      state  <= state_n;
      skip   <= skip_n;
      mod_q  <= mod_n;
      to_cnt <= '0;
    end else if (state != IDLE) begin
      if (PREFIX_TIMEOUT != 0 && to_cnt == TO_LAST) begin
        state  <= IDLE;
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end

  assign mods = {mod_q[5] | mod_q[4], mod_q[3] | mod_q[2], mod_q[1] | mod_q[0]};

  logic [12:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;

  assign full      = (count == FULL_CNT);
  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign do_push   = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

  assign {evt_code, evt_ext, evt_break, evt_mods} = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - directed self-checking bench for ps2_scancode_decoder
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_valid;
  logic [2:0] evt_mods, mods;
  logic       evt_ready = 1'b0;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(16)) dut (
    .clk(clk), .rst_l(rst_l), .byte_in(byte_in), .byte_valid(byte_valid),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .evt_mods(evt_mods), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .mods(mods), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // check head event fields then pop it
  task automatic expect_evt(input string tag, input logic [7:0] code, input logic ext,
                            input logic brk, input logic [2:0] m);
    check({tag, ".valid"}, evt_valid, 1);
    check({tag, ".event"}, {evt_code, evt_ext, evt_break, evt_mods}, {code, ext, brk, m});
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
  endtask

  initial begin
    #12;
    check("rst.valid", evt_valid, 0);
    check("rst.head", {evt_code, evt_ext, evt_break, evt_mods}, 0);
    check("rst.mods", mods, 0);
    check("rst.ovf", overflow, 0);
    rst_l = 1'b1;
    idle(2);

    // make / break
    send(8'h1C);
    expect_evt("make1c", 8'h1C, 0, 0, 3'b000);
    send(8'hF0);
    check("f0.noevt", evt_valid, 0);
    send(8'h1C);
    expect_evt("brk1c", 8'h1C, 0, 1, 3'b000);
    check("brk1c.empty", evt_valid, 0);

    // shift modifier
    send(8'h12);
    check("lshift.mods", mods, 3'b001);
    expect_evt("lshift", 8'h12, 0, 0, 3'b001);
    send(8'h1C);
    expect_evt("shift1c", 8'h1C, 0, 0, 3'b001);
    send(8'hF0); send(8'h12);
    check("lshift.rel", mods, 3'b000);
    expect_evt("lshiftbrk", 8'h12, 0, 1, 3'b000);
    check("shift.empty", evt_valid, 0);

    // extended keys, fake shift, right ctrl, ignored byte
    send(8'hE0); send(8'h75);
    expect_evt("e075", 8'h75, 1, 0, 3'b000);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_evt("e0f075", 8'h75, 1, 1, 3'b000);
    send(8'hE0); send(8'h12);
    check("fake.noevt", evt_valid, 0);
    check("fake.mods", mods, 3'b000);
    send(8'hE0); send(8'h14);
    check("rctrl.mods", mods, 3'b010);
    expect_evt("rctrl", 8'h14, 1, 0, 3'b010);
    send(8'hE0); send(8'hF0); send(8'h14);
    expect_evt("rctrlbrk", 8'h14, 1, 1, 3'b000);
    send(8'hAA);
    check("aa.ignored", evt_valid, 0);

    // pause sequence
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    check("pause.silent", evt_valid, 0);
    send(8'h77);
    check("pause.mods", mods, 3'b000);
    expect_evt("pause", 8'hE1, 0, 0, 3'b000);
    check("pause.one", evt_valid, 0);

    // FIFO fill and overflow
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    check("fill.noovf", overflow, 0);
    send(8'h2C);
    check("fill.ovf", overflow, 1);
    expect_evt("drain0", 8'h15, 0, 0, 3'b000);
    expect_evt("drain1", 8'h1D, 0, 0, 3'b000);
    expect_evt("drain2", 8'h24, 0, 0, 3'b000);
    expect_evt("drain3", 8'h2D, 0, 0, 3'b000);
    check("drain.empty", evt_valid, 0);
    check("ovf.sticky", overflow, 1);
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    check("ovf.clr", overflow, 0);

    // prefix timeout: below limit keeps prefix, beyond limit discards it
    send(8'hE0);
    idle(10);
    send(8'h75);
    expect_evt("to.kept", 8'h75, 1, 0, 3'b000);
    send(8'hE0);
    idle(20);
    send(8'h1C);
    expect_evt("to.expired", 8'h1C, 0, 0, 3'b000);

    // async reset mid-sequence drops queue and prefix
    send(8'h15);
    send(8'hF0);
    #2;
    rst_l = 1'b0;
    #1;
    check("rst2.valid", evt_valid, 0);
    rst_l = 1'b1;
    idle(1);
    send(8'h1C);
    expect_evt("rst2.make", 8'h1C, 0, 0, 3'b000);
    check("rst2.empty", evt_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream produced by the PS/2 keyboard receiver (one 8-bit scan code per strobe, Set 2) and turns it into buffered key events. Resolves E0 (extended), F0 (break) and E1 (Pause) prefixes, tracks Shift/Ctrl/Alt state, and queues events in a small FIFO with a valid/ready handshake for downstream logic or VeriFLA capture.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16
- PREFIX_TIMEOUT, 100000, clk cycles a pending prefix may wait for its next byte before being discarded; 0 disables the timeout
- clk  input  1  system clock, all logic on rising edge
- rst_l  input  1  asynchronous, active-low reset
- byte_in  input  8  scan code byte from the receiver
- byte_valid  input  1  one-cycle strobe; byte_in is valid in that cycle
- evt_code  output  8  scan code of head event (prefixes stripped)
- evt_ext  output  1  head event carried an E0 prefix
- evt_break  output  1  1 = key release, 0 = key press
- evt_mods  output  3  {alt, ctrl, shift} after applying this event
- evt_valid  output  1  FIFO non-empty; head fields valid
- evt_ready  input  1  consumer accepts head when evt_valid & evt_ready
- mods  output  3  live {alt, ctrl, shift}
- overflow  output  1  sticky: an event was dropped because FIFO was full
- clr_overflow  input  1  clears overflow (set wins if same cycle)

## Operation
- Reset: FSM IDLE, FIFO empty, evt_valid=0, evt_code/evt_ext/evt_break/evt_mods=0, mods=0, overflow=0, timeout counter=0.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Evaluated only on byte_valid.
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE (skip count 7); 00, AA, EE, FA, FC, FD, FE, FF -> stay, no event; other -> make event (ext=0), stay.
  - EXT: F0 -> EXT_BRK; E0/E1 -> restart (E0 -> EXT, E1 -> PAUSE); other -> make event (ext=1), IDLE.
  - BRK: any byte -> break event (ext=0), IDLE.
  - EXT_BRK: any byte -> break event (ext=1), IDLE.
  - PAUSE: consume 7 bytes silently; after 7th emit one make event code=E1, ext=0, IDLE.
- Fake shifts: extended 12 or 59 (make or break) emit no event and do not touch modifiers.
- Modifiers: internal lshift(12), rshift(59), lctrl(14), rctrl(E0 14), lalt(11), ralt(E0 11); set on make, cleared on break. shift=lshift|rshift, ctrl=lctrl|rctrl, alt=lalt|ralt. Modifier keys still produce events. evt_mods and mods reflect the update from the same byte.
- Timeout: counter runs while FSM not IDLE, reset on every byte_valid; at PREFIX_TIMEOUT cycles FSM -> IDLE, no event.
- FIFO push when an event is decoded; pop when evt_valid & evt_ready. Push accepted if not full, or full with pop in same cycle. Push to full FIFO without pop: event dropped, overflow=1, FIFO unchanged.
- Break of a key never pressed: event emitted normally, modifier bits cleared (already 0).

## Timing
- byte_valid at edge N -> FSM/mods updated at N+1; event written at N+1; evt_valid high after edge N+1 if FIFO was empty (one-cycle latency, head shown directly from storage).
- Pop at edge M: next entry (or evt_valid=0) visible after M.
- Simultaneous push and pop on empty FIFO impossible (evt_valid=0); on non-empty: count unchanged.
- Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
- Back-to-back byte_valid on consecutive cycles supported.
- rst_l low mid-sequence: immediate return to reset values, pending prefix and queued events lost.

## Test plan
- Bytes 1C, F0 1C, evt_ready=1 -> events {1C,ext0,brk0,mods0} then {1C,ext0,brk1,mods0}, each evt_valid one cycle after its final byte.
- 12, 1C, F0 12 -> mods=001 after 12; event 1C has evt_mods=001; after F0 12 mods=000; three events total.
- E0 75, E0 F0 75, E0 12 -> {75,ext1,brk0}, {75,ext1,brk1}; E0 12 produces no event, mods stays 0.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event code E1, no ctrl change.
- evt_ready=0, FIFO_DEPTH=4, send 5 make codes -> 4 queued, overflow=1; drain returns first 4 in order; clr_overflow -> 0.
- E0 then idle PREFIX_TIMEOUT cycles (param set 16), then 1C -> event {1C,ext0}; rst_l pulsed after F0 -> next 1C decoded as make.
